// File: rtl/addr_pair_sequencer_if.sv
// Command, datapath and response signals of addr_pair_sequencer.
// Carries done_cnt only when SEQ_DONE_CNT_EN is defined.
interface addr_pair_sequencer_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_src;
   logic [ADDR_W-1:0] cmd_dst;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic              ld_stb;
   logic              st_stb;
   logic [DATA_W-1:0] dp_result;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] rsp_dst;
   logic              busy;
`ifdef SEQ_DONE_CNT_EN
   logic [7:0]        done_cnt;

   modport master (
      output cmd_valid, cmd_src, cmd_dst, dp_result,
      input  cmd_ready, addr1, addr2, ld_stb, st_stb, rsp_valid, rsp_data, rsp_dst, busy, done_cnt
   );
   modport slave (
      input  cmd_valid, cmd_src, cmd_dst, dp_result,
      output cmd_ready, addr1, addr2, ld_stb, st_stb, rsp_valid, rsp_data, rsp_dst, busy, done_cnt
   );
`else
   modport master (
      output cmd_valid, cmd_src, cmd_dst, dp_result,
      input  cmd_ready, addr1, addr2, ld_stb, st_stb, rsp_valid, rsp_data, rsp_dst, busy
   );
   modport slave (
      input  cmd_valid, cmd_src, cmd_dst, dp_result,
      output cmd_ready, addr1, addr2, ld_stb, st_stb, rsp_valid, rsp_data, rsp_dst, busy
   );
`endif
endinterface

// File: rtl/addr_pair_sequencer.sv
// Queues (src,dst) commands and sequences addr2 -> settle -> addr1 -> settle -> response.
// Define SEQ_DONE_CNT_EN to add the 8-bit wrapping done_cnt response counter.
//
// state | meaning
// IDLE  | waiting for a queued command; pops head and drives addr2
// LOAD  | ld_stb cycle, arms settle timer
// LWAIT | settle after addr2; exit drives addr1
// STORE | st_stb cycle, arms settle timer
// SWAIT | settle after addr1; exit captures dp_result
// RESP  | rsp_valid cycle
module addr_pair_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int WAIT_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst,
   addr_pair_sequencer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, LWAIT, STORE, SWAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d, addr2_q, addr2_d, cur_dst_q, cur_dst_d;
   logic                ld_stb_q, ld_stb_d, st_stb_q, st_stb_d, rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0]   rsp_dst_q, rsp_dst_d;

   logic [2*ADDR_W-1:0] fifo_q [FIFO_DEPTH];
   logic [2*ADDR_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                full, push, pop;
   logic [2*ADDR_W-1:0] head;

   // Full is judged on the registered count, so a pop never frees a slot on its own edge.
   assign full          = (count_q == CNT_W'(FIFO_DEPTH));
   assign bus.cmd_ready = ~full & ~rst;
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign head          = fifo_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      addr1_d     = addr1_q;
      addr2_d     = addr2_q;
      cur_dst_d   = cur_dst_q;
      ld_stb_d    = 1'b0;
      st_stb_d    = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_dst_d   = rsp_dst_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               addr2_d   = head[2*ADDR_W-1:ADDR_W];
               cur_dst_d = head[ADDR_W-1:0];
               ld_stb_d  = 1'b1;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            tmr_d   = TMR_LOAD;
            state_d = LWAIT;
         end
         LWAIT: begin
            if (tmr_q == '0) begin
               addr1_d  = cur_dst_q;
               st_stb_d = 1'b1;
               state_d  = STORE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         STORE: begin
            tmr_d   = TMR_LOAD;
            state_d = SWAIT;
         end
         SWAIT: begin
            if (tmr_q == '0) begin
               rsp_data_d  = bus.dp_result;
               rsp_dst_d   = cur_dst_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {bus.cmd_src, bus.cmd_dst};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         addr1_q     <= '0;
         addr2_q     <= '0;
         cur_dst_q   <= '0;
         ld_stb_q    <= 1'b0;
         st_stb_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_dst_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         addr1_q     <= addr1_d;
         addr2_q     <= addr2_d;
         cur_dst_q   <= cur_dst_d;
         ld_stb_q    <= ld_stb_d;
         st_stb_q    <= st_stb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_dst_q   <= rsp_dst_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fifo_q      <= fifo_d;
      end
   end

   assign bus.addr1     = addr1_q;
   assign bus.addr2     = addr2_q;
   assign bus.ld_stb    = ld_stb_q;
   assign bus.st_stb    = st_stb_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_dst   = rsp_dst_q;
   assign bus.busy      = (state_q != IDLE) | (count_q != '0);

`ifdef SEQ_DONE_CNT_EN
   logic [7:0] done_cnt_q, done_cnt_d;

   assign done_cnt_d = done_cnt_q + 8'(rsp_valid_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) done_cnt_q <= '0;
      else     done_cnt_q <= done_cnt_d;
   end

   assign bus.done_cnt = done_cnt_q;
`endif
endmodule

// File: tb/tb_addr_pair_sequencer.sv
// Directed bench for addr_pair_sequencer: reset, single command latency, burst/back-pressure,
// mid-command reset, and done_cnt when SEQ_DONE_CNT_EN is defined.
module tb_addr_pair_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   addr_pair_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

   addr_pair_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   // Datapath stand-in: result depends on both addresses; {7,0} gives 8'hA5.
   function automatic logic [7:0] dp_f(input logic [3:0] s, input logic [3:0] d);
      return {s, d} ^ 8'hD5;
   endfunction

   assign bus_if.dp_result = dp_f(bus_if.addr2, bus_if.addr1);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " addr1"},     32'(bus_if.addr1), 0);
      check({tag, " addr2"},     32'(bus_if.addr2), 0);
      check({tag, " ld_stb"},    32'(bus_if.ld_stb), 0);
      check({tag, " st_stb"},    32'(bus_if.st_stb), 0);
      check({tag, " rsp_valid"}, 32'(bus_if.rsp_valid), 0);
      check({tag, " rsp_data"},  32'(bus_if.rsp_data), 0);
      check({tag, " rsp_dst"},   32'(bus_if.rsp_dst), 0);
      check({tag, " busy"},      32'(bus_if.busy), 0);
      check({tag, " cmd_ready"}, 32'(bus_if.cmd_ready), 0);
   endtask

`ifdef SEQ_DONE_CNT_EN
   task automatic run_cmds(input int n);
      int acc_n = 0;
      int cyc   = 0;
      logic a;
      bus_if.cmd_valid = 1'b1;
      while (acc_n < n && cyc < 20000) begin
         bus_if.cmd_src = 4'(acc_n);
         bus_if.cmd_dst = 4'(acc_n + 3);
         a = bus_if.cmd_valid & bus_if.cmd_ready;
         tick();
         cyc++;
         if (a) acc_n++;
      end
      bus_if.cmd_valid = 1'b0;
      while (bus_if.busy && cyc < 20000) begin
         tick();
         cyc++;
      end
      check("run_cmds within budget", 32'(cyc < 20000), 1);
   endtask
`endif

   logic [3:0] tbl_src [6] = '{4'h3, 4'h9, 4'hF, 4'h0, 4'hA, 4'h5};
   logic [3:0] tbl_dst [6] = '{4'hC, 4'h1, 4'h6, 4'hE, 4'h2, 4'h8};

   initial begin
      int   push_edge [6];
      int   rsp_edge  [6];
      int   n_push, n_rsp, pulses, busy_seen;
      logic acc, rdy5, rdy8, rdy9;

      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_src   = '0;
      bus_if.cmd_dst   = '0;

      // Reset held for two edges.
      tick();
      tick();
      check_cleared("reset");
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("ready after reset", 32'(bus_if.cmd_ready), 1);
      check("idle after reset", 32'(bus_if.busy), 0);

      // Single command src=7 dst=0.
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_src   = 4'h7;
      bus_if.cmd_dst   = 4'h0;
      tick();                                   // edge 0: push
      bus_if.cmd_valid = 1'b0;
      check("single busy e0", 32'(bus_if.busy), 1);
      check("single ld_stb e0", 32'(bus_if.ld_stb), 0);
      tick();                                   // edge 1
      check("single ld_stb e1", 32'(bus_if.ld_stb), 1);
      check("single addr2 e1", 32'(bus_if.addr2), 7);
      tick();                                   // edge 2
      check("single ld_stb e2", 32'(bus_if.ld_stb), 0);
      tick();                                   // edge 3
      check("single st_stb e3", 32'(bus_if.st_stb), 0);
      tick();                                   // edge 4
      check("single st_stb e4", 32'(bus_if.st_stb), 1);
      check("single addr1 e4", 32'(bus_if.addr1), 0);
      tick();                                   // edge 5
      check("single st_stb e5", 32'(bus_if.st_stb), 0);
      tick();                                   // edge 6
      check("single rsp_valid e6", 32'(bus_if.rsp_valid), 0);
      tick();                                   // edge 7
      check("single rsp_valid e7", 32'(bus_if.rsp_valid), 1);
      check("single rsp_data e7", 32'(bus_if.rsp_data), 32'hA5);
      check("single rsp_dst e7", 32'(bus_if.rsp_dst), 0);
      tick();                                   // edge 8
      check("single rsp_valid e8", 32'(bus_if.rsp_valid), 0);
      check("single busy e8", 32'(bus_if.busy), 0);
      check("single addr2 hold", 32'(bus_if.addr2), 7);

      // Burst of six with cmd_valid held; edge 0 is the first push.
      n_push = 0;
      n_rsp  = 0;
      rdy5   = 1'b1;
      rdy8   = 1'b1;
      rdy9   = 1'b0;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_src   = tbl_src[0];
      bus_if.cmd_dst   = tbl_dst[0];
      for (int e = 0; e < 120 && n_rsp < 6; e++) begin
         acc = bus_if.cmd_valid & bus_if.cmd_ready;
         tick();
         if (acc) begin
            push_edge[n_push] = e;
            n_push++;
            if (n_push < 6) begin
               bus_if.cmd_src = tbl_src[n_push];
               bus_if.cmd_dst = tbl_dst[n_push];
            end else begin
               bus_if.cmd_valid = 1'b0;
            end
         end
         if (e == 5) rdy5 = bus_if.cmd_ready;
         if (e == 8) rdy8 = bus_if.cmd_ready;
         if (e == 9) rdy9 = bus_if.cmd_ready;
         if (bus_if.rsp_valid) begin
            check($sformatf("burst rsp%0d data", n_rsp), 32'(bus_if.rsp_data),
                  32'(dp_f(tbl_src[n_rsp], tbl_dst[n_rsp])));
            check($sformatf("burst rsp%0d dst", n_rsp), 32'(bus_if.rsp_dst), 32'(tbl_dst[n_rsp]));
            rsp_edge[n_rsp] = e;
            n_rsp++;
         end
      end
      bus_if.cmd_valid = 1'b0;
      check("burst pushes", 32'(n_push), 6);
      check("burst responses", 32'(n_rsp), 6);
      if (n_push == 6) begin
         check("burst push5 edge", 32'(push_edge[4]), 4);
         check("burst push6 edge", 32'(push_edge[5]), 10);
      end
      check("burst full ready e5", 32'(rdy5), 0);
      check("burst full+pop ready e8", 32'(rdy8), 0);
      check("burst ready after pop e9", 32'(rdy9), 1);
      for (int k = 0; k < n_rsp; k++)
         check($sformatf("burst rsp%0d edge", k), 32'(rsp_edge[k]), 32'(7 + 8 * k));
      tick();
      check("burst idle", 32'(bus_if.busy), 0);

      // Reset during SWAIT of the first of three commands (two still queued).
      bus_if.cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_if.cmd_src = 4'(i + 1);
         bus_if.cmd_dst = 4'(i + 9);
         tick();                                // edges 0..2
      end
      bus_if.cmd_valid = 1'b0;
      tick();                                   // edge 3
      tick();                                   // edge 4
      check("mid st_stb e4", 32'(bus_if.st_stb), 1);
      check("mid addr1 e4", 32'(bus_if.addr1), 9);
      tick();                                   // edge 5: in SWAIT
      rst = 1'b1;
      #1;
      check_cleared("mid reset");
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      pulses    = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         pulses    += int'(bus_if.rsp_valid) + int'(bus_if.ld_stb) + int'(bus_if.st_stb);
         busy_seen += int'(bus_if.busy);
      end
      check("mid no pulses after reset", 32'(pulses), 0);
      check("mid never busy after reset", 32'(busy_seen), 0);
      check("mid addr1 cleared", 32'(bus_if.addr1), 0);
      check("mid addr2 cleared", 32'(bus_if.addr2), 0);

`ifdef SEQ_DONE_CNT_EN
      check("done_cnt after reset", 32'(bus_if.done_cnt), 0);
      run_cmds(3);
      check("done_cnt 3", 32'(bus_if.done_cnt), 3);
      run_cmds(254);
      check("done_cnt wrap 257", 32'(bus_if.done_cnt), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
